// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader:
//   the frame-parser state encoding, the frame start marker and the
//   width of the running payload checksum.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        FIN_OK,
        FIN_ERR
    } state_t;

    localparam logic [7:0] MAGIC  = 8'hA5;
    localparam int         CSUM_W = 8;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction RAM. Parses a framed byte stream
//   (A5, N lo, N hi, 4*N payload bytes, checksum), packs payload bytes
//   little-endian into 32-bit words and writes them sequentially from
//   BASE_ADDR. The core is held in reset until a frame with a matching
//   checksum has been fully written.
//
// Ports
//   CLK       clock, all logic on rising edge
//   RST       synchronous active-high reset
//   RX_DATA   incoming byte
//   RX_VALID  RX_DATA valid this cycle
//   RX_READY  loader accepts a byte this cycle (low only in WRITE)
//   WE        one-cycle write strobe per word
//   WA        byte address of the write (word aligned)
//   WD        write data
//   BUSY      frame in progress
//   DONE      last frame completed with a good checksum
//   ERR       last frame rejected (bad checksum or oversize length)
//   CPU_HOLD  active-high reset request to the core
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no frame seen since reset; waiting for the magic byte
// LEN_LO  | expecting low byte of the word count
// LEN_HI  | expecting high byte of the word count; length is judged here
// DATA    | collecting payload bytes of the current word
// WRITE   | single cycle: word presented on WE/WA/WD, input stalled
// CSUM    | expecting the checksum byte
// FIN_OK  | last frame good; core released; waiting for next magic byte
// FIN_ERR | last frame rejected; core held; waiting for next magic byte
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        WE,
    output logic [31:0] WA,
    output logic [31:0] WD,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        CPU_HOLD
);

    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    state_t              state;
    logic [15:0]         len;
    logic [15:0]         idx;
    logic [CSUM_W-1:0]   csum;
    logic [1:0]          lane;
    // Holds the first three bytes of a word; the fourth byte is merged
    // straight into WD on the cycle it arrives.
    logic [23:0]         pack;

    logic                accept;
    logic [15:0]         len_full;
    logic                len_oversize;
    logic [15:0]         idx_next;
    logic [CSUM_W-1:0]   csum_next;

    always_comb begin
        accept       = RX_VALID && RX_READY;
        len_full     = {RX_DATA, len[7:0]};
        len_oversize = ({16'd0, len_full} > DEPTH_L);
        idx_next     = idx + 16'd1;
        csum_next    = csum + RX_DATA[CSUM_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            len      <= '0;
            idx      <= '0;
            csum     <= '0;
            lane     <= '0;
            pack     <= '0;
            RX_READY <= 1'b1;
            WE       <= 1'b0;
            WA       <= '0;
            WD       <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            CPU_HOLD <= 1'b1;
        end else begin
            WE <= 1'b0;
            unique case (state)
                IDLE, FIN_OK, FIN_ERR: begin
                    if (accept && RX_DATA == MAGIC) begin
                        state    <= LEN_LO;
                        BUSY     <= 1'b1;
                        CPU_HOLD <= 1'b1;
                        DONE     <= 1'b0;
                        ERR      <= 1'b0;
                        idx      <= '0;
                        csum     <= '0;
                        lane     <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= RX_DATA;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len <= len_full;
                        if (len_oversize) begin
                            state <= FIN_ERR;
                            ERR   <= 1'b1;
                            BUSY  <= 1'b0;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum_next;
                        lane <= lane + 2'd1;
                        pack <= {RX_DATA, pack[23:8]};
                        if (lane == 2'd3) begin
                            state    <= WRITE;
                            RX_READY <= 1'b0;
                            WE       <= 1'b1;
                            WA       <= BASE_ADDR + {14'd0, idx, 2'b00};
                            WD       <= {RX_DATA, pack};
                        end
                    end
                end
                WRITE: begin
                    RX_READY <= 1'b1;
                    idx      <= idx_next;
                    state    <= (idx_next == len) ? CSUM : DATA;
                end
                CSUM: begin
                    if (accept) begin
                        BUSY <= 1'b0;
                        if (RX_DATA[CSUM_W-1:0] == csum) begin
                            state    <= FIN_OK;
                            DONE     <= 1'b1;
                            CPU_HOLD <= 1'b0;
                        end else begin
                            state <= FIN_ERR;
                            ERR   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic        WE;
    logic [31:0] WA;
    logic [31:0] WD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        CPU_HOLD;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];

    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .WE(WE), .WA(WA), .WD(WD), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .CPU_HOLD(CPU_HOLD)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic exp_write(input logic [31:0] wa, input logic [31:0] wd);
        exp_wa_q.push_back(wa);
        exp_wd_q.push_back(wd);
    endtask

    // Monitor: pops one expected write per WE strobe.
    always @(negedge CLK) begin
        if (!RST) begin
            check("rx_ready_vs_we", {31'd0, RX_READY}, {31'd0, ~WE});
            if (WE) begin
                if (exp_wa_q.size() == 0) begin
                    check("unexpected_we_wa", WA, 32'hFFFF_FFFF);
                end else begin
                    check("write_wa", WA, exp_wa_q.pop_front());
                    check("write_wd", WD, exp_wd_q.pop_front());
                end
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the accepting edge.
    task automatic send_bytes(input byte_q_t b, input bit stall);
        foreach (b[i]) begin
            if (stall) begin
                int gap = $urandom_range(0, 2);
                RX_VALID = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    @(posedge CLK);
                    #1;
                end
            end
            RX_DATA  = b[i];
            RX_VALID = 1'b1;
            begin
                bit got = 1'b0;
                for (int t = 0; t < 20 && !got; t++) begin
                    got = RX_READY;
                    @(posedge CLK);
                    #1;
                end
                if (!got) check("byte_accept_timeout", 32'd0, 32'd1);
            end
        end
        RX_VALID = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit busy, input bit done,
                                input bit err, input bit hold);
        check({tag, "_busy"}, {31'd0, BUSY}, {31'd0, busy});
        check({tag, "_done"}, {31'd0, DONE}, {31'd0, done});
        check({tag, "_err"},  {31'd0, ERR},  {31'd0, err});
        check({tag, "_hold"}, {31'd0, CPU_HOLD}, {31'd0, hold});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'd0, RX_READY}, 32'd1);
        check({tag, "_we"}, {31'd0, WE}, 32'd0);
        check({tag, "_wa"}, WA, 32'd0);
        check({tag, "_wd"}, WD, 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    byte_q_t good_frame;
    byte_q_t bad_frame;

    initial begin
        good_frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h01, 8'h30, 8'h04,
                       8'h13, 8'h01, 8'h20, 8'h00, 8'hFC};
        bad_frame  = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h01, 8'h30, 8'h04,
                       8'h13, 8'h01, 8'h20, 8'h00, 8'hFD};

        RST = 1'b1;
        idle_cycles(2);
        check_reset_values("reset");
        RST = 1'b0;
        idle_cycles(1);

        // Junk bytes, then a good frame
        send_bytes('{8'h00, 8'hFF, 8'h13}, 1'b0);
        check_status("junk", 1'b0, 1'b0, 1'b0, 1'b1);
        exp_write(32'h0, 32'h04300193);
        exp_write(32'h4, 32'h00200113);
        send_bytes(good_frame, 1'b0);
        check_status("good", 1'b0, 1'b1, 1'b0, 1'b0);

        // Bad checksum
        exp_write(32'h0, 32'h04300193);
        exp_write(32'h4, 32'h00200113);
        send_bytes(bad_frame, 1'b0);
        check_status("badsum", 1'b0, 1'b0, 1'b1, 1'b1);

        // Empty frame
        send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
        check_status("empty", 1'b0, 1'b1, 1'b0, 1'b0);

        // Oversize frame, trailing bytes ignored
        send_bytes('{8'hA5, 8'h01, 8'h01}, 1'b0);
        check_status("oversize", 1'b0, 1'b0, 1'b1, 1'b1);
        send_bytes('{8'h93, 8'h01, 8'h30, 8'h04, 8'h13}, 1'b0);
        check_status("oversize_tail", 1'b0, 1'b0, 1'b1, 1'b1);

        // Good frame with random RX_VALID gaps
        exp_write(32'h0, 32'h04300193);
        exp_write(32'h4, 32'h00200113);
        send_bytes(good_frame, 1'b1);
        check_status("stall", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset after 5 payload bytes: first word written, second dropped
        exp_write(32'h0, 32'h04300193);
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h93, 8'h01, 8'h30, 8'h04, 8'h13}, 1'b0);
        check_status("midload", 1'b1, 1'b0, 1'b0, 1'b1);
        RST = 1'b1;
        idle_cycles(1);
        check_reset_values("midreset");
        RST = 1'b0;
        idle_cycles(2);
        check("midreset_quiet_we", {31'd0, WE}, 32'd0);
        exp_write(32'h0, 32'h04300193);
        exp_write(32'h4, 32'h00200113);
        send_bytes(good_frame, 1'b0);
        check_status("after_reset", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reload: magic byte re-holds the core, then new words overwrite
        send_bytes('{8'hA5}, 1'b0);
        check_status("reload_start", 1'b1, 1'b0, 1'b0, 1'b1);
        exp_write(32'h0, 32'hDEADBEEF);
        exp_write(32'h4, 32'h000000A5);
        // A5 inside the payload is data; sum = EF+BE+AD+DE+A5 = 0x3DD -> DD
        send_bytes('{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                     8'hA5, 8'h00, 8'h00, 8'h00, 8'hDD}, 1'b0);
        check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0);

        idle_cycles(4);
        check("pending_writes", exp_wa_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
